// File: rtl/system_multi_timer_pkg.sv
// Shared register map and bit positions for the multi-channel interval timer.
package system_multi_timer_pkg;

    localparam logic [1:0] REG_STATUS  = 2'd0;
    localparam logic [1:0] REG_CONTROL = 2'd1;
    localparam logic [1:0] REG_PERIOD  = 2'd2;
    localparam logic [1:0] REG_SNAP    = 2'd3;

    localparam int unsigned STAT_TO  = 0;
    localparam int unsigned STAT_RUN = 1;
    localparam int unsigned STAT_OVR = 2;

    localparam int unsigned CTRL_ITO   = 0;
    localparam int unsigned CTRL_CONT  = 1;
    localparam int unsigned CTRL_START = 2;
    localparam int unsigned CTRL_STOP  = 3;

    localparam int unsigned PRESCALE_LSB = 8;

endpackage

// File: rtl/system_multi_timer_channel.sv
// One timer channel: prescaled down-counter, control/status flags, period and snapshot.
module system_multi_timer_channel
    import system_multi_timer_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH    = 32,
    parameter int unsigned PRESCALE_WIDTH = 8,
    parameter int unsigned DEFAULT_PERIOD = 49999
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_wr_status,
    input  logic        i_wr_control,
    input  logic        i_wr_period,
    input  logic        i_wr_snap,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_rsel,
    output logic [31:0] o_rdata,
    output logic        o_irq
);

    localparam logic [COUNT_WIDTH-1:0] RESET_PERIOD = COUNT_WIDTH'(DEFAULT_PERIOD);

    logic [COUNT_WIDTH-1:0]    r_count;
    logic [COUNT_WIDTH-1:0]    r_period;
    logic [COUNT_WIDTH-1:0]    r_snap;
    logic [PRESCALE_WIDTH-1:0] r_pscnt;
    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic r_ito, r_cont, r_run, r_to, r_ovr, r_reload;
    logic w_start, w_stop, w_tick, w_timeout;

    assign w_start   = i_wr_control && i_wdata[CTRL_START];
    assign w_stop    = i_wr_control && i_wdata[CTRL_STOP];
    // A pending forced reload suppresses counting for that cycle.
    assign w_tick    = r_run && (r_pscnt == '0) && !r_reload;
    assign w_timeout = w_tick && (r_count == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count    <= RESET_PERIOD;
            r_period   <= RESET_PERIOD;
            r_snap     <= '0;
            r_pscnt    <= '0;
            r_prescale <= '0;
            r_ito      <= 1'b0;
            r_cont     <= 1'b0;
            r_run      <= 1'b0;
            r_to       <= 1'b0;
            r_ovr      <= 1'b0;
            r_reload   <= 1'b0;
        end else begin
            r_reload <= i_wr_period;
            if (i_wr_period) r_period <= i_wdata[COUNT_WIDTH-1:0];
            if (i_wr_control) begin
                r_ito      <= i_wdata[CTRL_ITO];
                r_cont     <= i_wdata[CTRL_CONT];
                r_prescale <= i_wdata[PRESCALE_LSB +: PRESCALE_WIDTH];
            end
            if (i_wr_snap) r_snap <= r_count;

            if (r_reload) begin
                r_count <= r_period;
            end else if (w_tick) begin
                r_count <= (r_count == '0) ? r_period : r_count - COUNT_WIDTH'(1);
            end

            if (w_start || r_reload) begin
                r_pscnt <= '0;
            end else if (w_tick) begin
                r_pscnt <= r_prescale;
            end else if (r_run) begin
                r_pscnt <= r_pscnt - PRESCALE_WIDTH'(1);
            end

            if (w_start) begin
                r_run <= 1'b1;
            end else if (r_reload || w_stop || (w_timeout && !r_cont)) begin
                r_run <= 1'b0;
            end

            // Timeout outranks a status clear for TO; the clear outranks OVR.
            if (w_timeout) begin
                r_to <= 1'b1;
            end else if (i_wr_status) begin
                r_to <= 1'b0;
            end
            if (i_wr_status) begin
                r_ovr <= 1'b0;
            end else if (w_timeout && r_to) begin
                r_ovr <= 1'b1;
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        unique case (i_rsel)
            REG_STATUS: begin
                o_rdata[STAT_TO]  = r_to;
                o_rdata[STAT_RUN] = r_run;
                o_rdata[STAT_OVR] = r_ovr;
            end
            REG_CONTROL: begin
                o_rdata[CTRL_ITO]                          = r_ito;
                o_rdata[CTRL_CONT]                         = r_cont;
                o_rdata[PRESCALE_LSB +: PRESCALE_WIDTH] = r_prescale;
            end
            REG_PERIOD: o_rdata = 32'(r_period);
            REG_SNAP:   o_rdata = 32'(r_snap);
        endcase
    end

    assign o_irq = r_to && r_ito;

endmodule

// File: rtl/system_multi_timer.sv
// Avalon-MM multi-channel interval timer: address decode, registered read mux, irq reduction.
module system_multi_timer
    import system_multi_timer_pkg::*;
#(
    parameter int unsigned CHANNELS       = 4,
    parameter int unsigned COUNT_WIDTH    = 32,
    parameter int unsigned PRESCALE_WIDTH = 8,
    parameter int unsigned DEFAULT_PERIOD = 49999
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [$clog2(CHANNELS)+1:0]   address,
    input  logic                          chipselect,
    input  logic                          write_n,
    input  logic [31:0]                   writedata,
    output logic [31:0]                   readdata,
    output logic                          irq,
    output logic [CHANNELS-1:0]           irq_vec
);

    localparam int unsigned ADDR_WIDTH = $clog2(CHANNELS) + 2;

    logic [ADDR_WIDTH-1:0] w_chan;
    logic [1:0]            w_reg;
    logic                  w_wr;
    logic [31:0]           w_rdata [CHANNELS];
    logic [31:0]           w_rd_mux;

    // Channel indices at or beyond CHANNELS match no instance: writes drop, reads give 0.
    assign w_chan = address >> 2;
    assign w_reg  = address[1:0];
    assign w_wr   = chipselect && !write_n;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic w_sel;
        assign w_sel = w_wr && (w_chan == ADDR_WIDTH'(g));

        system_multi_timer_channel #(
            .COUNT_WIDTH    (COUNT_WIDTH),
            .PRESCALE_WIDTH (PRESCALE_WIDTH),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_channel (
            .clk          (clk),
            .reset_n      (reset_n),
            .i_wr_status  (w_sel && (w_reg == REG_STATUS)),
            .i_wr_control (w_sel && (w_reg == REG_CONTROL)),
            .i_wr_period  (w_sel && (w_reg == REG_PERIOD)),
            .i_wr_snap    (w_sel && (w_reg == REG_SNAP)),
            .i_wdata      (writedata),
            .i_rsel       (w_reg),
            .o_rdata      (w_rdata[g]),
            .o_irq        (irq_vec[g])
        );
    end

    always_comb begin
        w_rd_mux = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_chan == ADDR_WIDTH'(c)) w_rd_mux = w_rdata[c];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= w_rd_mux;
        end
    end

    assign irq = |irq_vec;

endmodule

// File: tb/tb_system_multi_timer.sv
// Bench for system_multi_timer: directed scenarios plus random bus traffic against a reference model.
module tb_system_multi_timer;

    localparam int unsigned DEF = 49999;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  address;
    logic        chipselect, write_n, cs3;
    logic [31:0] writedata, readdata, readdata3;
    logic        irq, irq3;
    logic [3:0]  irq_vec;
    logic [2:0]  irq_vec3;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state, one entry per channel.
    bit [31:0] m_cnt [4];
    bit [31:0] m_per [4];
    bit [31:0] m_snap [4];
    int        m_ps [4];
    int        m_pre [4];
    bit        m_ito [4], m_cont [4], m_run [4], m_to [4], m_ovr [4], m_pend [4];
    bit [31:0] m_rdata;

    system_multi_timer u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .irq_vec    (irq_vec)
    );

    // Three channels: channel index 3 is out of range on the same 4-bit address bus.
    system_multi_timer #(.CHANNELS(3)) u_dut3 (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (cs3),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata3),
        .irq        (irq3),
        .irq_vec    (irq_vec3)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            m_cnt[c] = DEF;  m_per[c] = DEF;  m_snap[c] = 0;
            m_ps[c] = 0;     m_pre[c] = 0;
            m_ito[c] = 0; m_cont[c] = 0; m_run[c] = 0;
            m_to[c] = 0;  m_ovr[c] = 0;  m_pend[c] = 0;
        end
        m_rdata = 0;
    endtask

    function automatic bit [31:0] mread(int ch, int rg);
        case (rg)
            0:       return {29'd0, m_ovr[ch], m_run[ch], m_to[ch]};
            1:       return (32'(m_pre[ch]) << 8) | {30'd0, m_cont[ch], m_ito[ch]};
            2:       return m_per[ch];
            default: return m_snap[ch];
        endcase
    endfunction

    function automatic bit [3:0] mvec();
        bit [3:0] v;
        for (int c = 0; c < 4; c++) v[c] = m_to[c] & m_ito[c];
        return v;
    endfunction

    // Advance the model by one clock edge using the bus values held across that edge.
    task automatic model_update();
        int ch, rg;
        bit wr_en, w, ws, wc, wp, wn, start, stop, tick, tout;
        bit [31:0] rd;
        ch = int'(address[3:2]);
        rg = int'(address[1:0]);
        rd = mread(ch, rg);
        wr_en = chipselect && !write_n;
        for (int c = 0; c < 4; c++) begin
            w  = wr_en && (ch == c);
            ws = w && (rg == 0);
            wc = w && (rg == 1);
            wp = w && (rg == 2);
            wn = w && (rg == 3);
            start = wc && writedata[2];
            stop  = wc && writedata[3];
            tick  = m_run[c] && (m_ps[c] == 0) && !m_pend[c];
            tout  = tick && (m_cnt[c] == 0);
            if (wn) m_snap[c] = m_cnt[c];
            if (m_pend[c]) m_cnt[c] = m_per[c];
            else if (tick) m_cnt[c] = tout ? m_per[c] : m_cnt[c] - 1;
            if (start || m_pend[c]) m_ps[c] = 0;
            else if (tick) m_ps[c] = m_pre[c];
            else if (m_run[c]) m_ps[c] = m_ps[c] - 1;
            if (start) m_run[c] = 1;
            else if (m_pend[c] || stop || (tout && !m_cont[c])) m_run[c] = 0;
            if (ws) m_ovr[c] = 0;
            else if (tout && m_to[c]) m_ovr[c] = 1;
            if (tout) m_to[c] = 1;
            else if (ws) m_to[c] = 0;
            if (wc) begin
                m_ito[c]  = writedata[0];
                m_cont[c] = writedata[1];
                m_pre[c]  = int'(writedata[15:8]);
            end
            if (wp) m_per[c] = writedata;
            m_pend[c] = wp;
        end
        m_rdata = rd;
    endtask

    task automatic cyc();
        bit [3:0] ev;
        @(posedge clk);
        if (reset_n) model_update();
        #1;
        ev = mvec();
        check("readdata", readdata, m_rdata);
        check("irq_vec", {28'd0, irq_vec}, {28'd0, ev});
        check("irq", {31'd0, irq}, {31'd0, |ev});
    endtask

    task automatic wr(int a, logic [31:0] d);
        address = 4'(a); writedata = d; chipselect = 1'b1; write_n = 1'b0;
        cyc();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic wr3(int a, logic [31:0] d);
        address = 4'(a); writedata = d; cs3 = 1'b1; write_n = 1'b0;
        cyc();
        cs3 = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(int a, output logic [31:0] v);
        address = 4'(a);
        cyc();
        v = readdata;
    endtask

    task automatic idle(int n);
        repeat (n) cyc();
    endtask

    initial begin
        logic [31:0] v, d;
        int lat;
        int unsigned ch, rg, act;

        reset_n = 1'b0; address = '0; chipselect = 1'b0; cs3 = 1'b0;
        write_n = 1'b1; writedata = '0;
        model_reset();
        #2;
        check("reset_readdata", readdata, 0);
        check("reset_irq", {31'd0, irq}, 0);
        #20 reset_n = 1'b1;

        rd(2, v);  check("reset_ch0_period", v, DEF);
        rd(0, v);  check("reset_ch0_status", v, 0);

        // ch1 continuous, PERIOD=4, prescale 0: timeout every 5 cycles.
        wr(6, 4); wr(5, 32'h3); wr(5, 32'h7);
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            cyc();
            if (irq_vec[1]) lat = i;
        end
        check("ch1_first_timeout", 32'(lat), 5);
        check("ch1_irq", {31'd0, irq}, 1);
        wr(4, 0);
        check("ch1_irq_cleared", {31'd0, irq_vec[1]}, 0);
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            cyc();
            if (irq_vec[1]) lat = i;
        end
        check("ch1_next_timeout", 32'(lat), 4);
        wr(5, 32'hB); wr(4, 0);
        rd(5, v);  check("ch1_control_read", v, 32'h3);

        // ch2 one-shot, PERIOD=2, PRESCALE=3; prescaler starts at 0 so the first tick is immediate.
        wr(10, 2); wr(9, 32'h301); wr(9, 32'h305);
        lat = 0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            cyc();
            if (irq_vec[2]) lat = i;
        end
        check("ch2_oneshot_timeout", 32'(lat), 9);
        rd(8, v);  check("ch2_status_stopped", v, 32'h1);
        wr(11, 0);
        rd(11, v); check("ch2_holds_period", v, 2);
        idle(50);
        rd(8, v);  check("ch2_no_second_timeout", v, 32'h1);
        wr(8, 0);

        // ch0 continuous PERIOD=1: overrun, then status clear on a timeout edge.
        wr(2, 1); wr(1, 32'h3); wr(1, 32'h7);
        idle(4);
        rd(0, v);  check("ch0_overrun", v, 32'h7);
        wr(0, 0);
        rd(0, v);  check("ch0_clear_vs_timeout", v, 32'h3);
        wr(1, 32'h8); wr(0, 0);

        // ch3 force reload on PERIOD write, then START+STOP restarts.
        wr(14, 100); wr(13, 32'h2); wr(13, 32'h6);
        idle(5);
        wr(14, 10); idle(1); wr(15, 0);
        rd(15, v); check("ch3_snapshot_reload", v, 10);
        rd(12, v); check("ch3_run_cleared", v, 0);
        wr(13, 32'hE);
        rd(12, v); check("ch3_start_wins", v, 32'h2);
        wr(13, 32'h8);

        // Out-of-range channel on the three-channel instance.
        wr3(13, 32'h307); wr3(14, 5);
        rd(13, v); check("oor_control_read", readdata3, 0);
        rd(12, v); check("oor_status_read", readdata3, 0);
        rd(14, v); check("oor_period_read", readdata3, 0);
        rd(2, v);  check("oor_no_alias", readdata3, DEF);
        idle(5);
        check("oor_irq", {31'd0, irq3}, 0);

        // Random register traffic, every cycle compared to the model.
        for (int n = 0; n < 1500; n++) begin
            ch  = $urandom_range(0, 3);
            rg  = $urandom_range(0, 3);
            act = $urandom_range(0, 9);
            if (act < 3) begin
                case (rg)
                    1:       d = ($urandom_range(0, 3) << 8) | $urandom_range(0, 15);
                    2:       d = $urandom_range(0, 12);
                    default: d = $urandom;
                endcase
                wr(int'(ch * 4 + rg), d);
            end else begin
                address = 4'($urandom_range(0, 15));
                cyc();
            end
        end

        // Asynchronous reset in the middle of a count.
        wr(2, 3); wr(1, 32'h3); wr(1, 32'h7);
        idle(9);
        #3 reset_n = 1'b0;
        #1;
        check("async_rst_readdata", readdata, 0);
        check("async_rst_irq", {31'd0, irq}, 0);
        check("async_rst_irq_vec", {28'd0, irq_vec}, 0);
        model_reset();
        cyc(); cyc();
        #3 reset_n = 1'b1;
        rd(2, v);  check("post_rst_period", v, DEF);
        rd(1, v);  check("post_rst_control", v, 0);
        rd(0, v);  check("post_rst_status", v, 0);
        idle(20);
        wr(3, 0);
        rd(3, v);  check("post_rst_not_running", v, DEF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
